// File: rtl/alu_serial_sequencer_pkg.sv
// Shared opcodes and FSM encoding for the bit-serial ALU engine.
package alu_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_slice_1b.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add, carry from inverted operands.
module alu_slice_1b
  import alu_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       cin,
  input  logic [3:0] alu_op,
  output logic       res,
  output logic       cout
);

  logic a_eff;
  logic b_eff;

  // Slice function; carry is always produced so the top can chain it for ADD.
  always_comb begin
    a_eff = ai ^ alu_op[3];
    b_eff = bi ^ alu_op[2];
    cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
    if (alu_op[1])      res = a_eff ^ b_eff ^ cin;
    else if (alu_op[0]) res = a_eff | b_eff;
    else                res = a_eff & b_eff;
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: one slice, WIDTH cycles per operation, LSB first.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | processing bit cnt_q of the latched operands
//   S_DONE | done pulse; result/flags just updated, start may chain a new op
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic [3:0]           op_q, op_d;
  logic                 c_q, c_d;
  // Holds bits 0..WIDTH-2; the final bit goes straight into result.
  logic [WIDTH-2:0]     res_sh_q, res_sh_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  logic                 slice_res;
  logic                 slice_cout;
  logic [WIDTH-1:0]     res_full;

  alu_slice_1b u_slice (
    .ai     (a_sh_q[0]),
    .bi     (b_sh_q[0]),
    .cin    (c_q),
    .alu_op (op_q),
    .res    (slice_res),
    .cout   (slice_cout)
  );

  // Next-state, datapath shifting and output-flag capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    c_d      = c_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    res_full = {slice_res, res_sh_q};

    if (state_q == S_RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      res_sh_d = res_full[WIDTH-1:1];
      c_d      = slice_cout;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_BIT) begin
        state_d  = S_DONE;
        result_d = res_full;
        zero_d   = (res_full == '0);
        cout_d   = op_q[1] & slice_cout;
        // c_q here is the carry into the MSB.
        ovf_d    = op_q[1] & (c_q ^ slice_cout);
      end
    end else begin
      if (state_q == S_DONE) state_d = S_IDLE;
      if (start) begin
        state_d = S_RUN;
        a_sh_d  = a;
        b_sh_d  = b;
        op_d    = alu_op;
        c_d     = alu_op[2];
        cnt_d   = '0;
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= '0;
      c_q      <= 1'b0;
      res_sh_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      op_q     <= op_d;
      c_q      <= c_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops them on done.
module tb_alu_serial_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_i = '0, b_i = '0;
  logic [3:0]    op_i = '0;
  logic          busy, done, zero, carry_out, overflow;
  logic [W-1:0]  result;

  logic          start64 = 1'b0;
  logic [63:0]   a64 = '0, b64 = '0;
  logic [3:0]    op64 = '0;
  logic          busy64, done64, zero64, cout64, ovf64;
  logic [63:0]   result64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   busy_cnt = 0;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .alu_op(op_i),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry_out(carry_out), .overflow(overflow)
  );

  alu_serial_sequencer #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .a(a64), .b(b64), .alu_op(op64),
    .busy(busy64), .done(done64), .result(result64), .zero(zero64),
    .carry_out(cout64), .overflow(ovf64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: whole-word arithmetic on the (optionally inverted) operands.
  function automatic exp_t model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                 input logic [3:0] op);
    exp_t e;
    logic [W-1:0] aa, bb;
    int unsigned s;
    aa = op[3] ? ~ra : ra;
    bb = op[2] ? ~rb : rb;
    e.c = 1'b0;
    e.v = 1'b0;
    e.t0 = 0;
    if (op[1]) begin
      s = int'(aa) + int'(bb) + (op[2] ? 1 : 0);
      e.res = s[W-1:0];
      e.c = s[W];
      e.v = (aa[W-1] == bb[W-1]) && (e.res[W-1] != aa[W-1]);
    end else if (op[0]) begin
      e.res = aa | bb;
    end else begin
      e.res = aa & bb;
    end
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: pops on done, otherwise the outputs must hold their last value.
  always @(negedge clk) begin
    if (!rst_n) begin
      last.res = '0; last.z = 1'b0; last.c = 1'b0; last.v = 1'b0;
      busy_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done cyc=%0d result=%0h", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags{z,c,v}", {zero, carry_out, overflow}, {e.z, e.c, e.v});
        chk("latency", cyc - e.t0, W + 1);
        chk("busy_cycles", busy_cnt, W);
        last = e;
      end
      busy_cnt = 0;
    end else begin
      chk("hold", {result, zero, carry_out, overflow}, {last.res, last.z, last.c, last.v});
      if (busy) busy_cnt++;
    end
  end

  // Drive a request at posedge+1; it is accepted on the following edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] op, input bit push);
    exp_t e;
    a_i = ia; b_i = ib; op_i = op; start = 1'b1;
    if (push) begin
      e = model(ia, ib, op);
      e.t0 = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); op_i = 4'($urandom);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done timeout cyc=%0d", cyc);
    end
  endtask

  initial begin
    int n;
    int t0;
    step(2);
    #1;
    chk("reset_outputs", {busy, done, result, zero, carry_out, overflow}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // 64-bit SUB 0 - 1
    a64 = 64'h0; b64 = 64'h1; op64 = ALUOP_SUB; start64 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    n = 0;
    while (!done64 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w64_latency", cyc - t0, 65);
    chk("w64_result", result64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_flags{z,c,v}", {zero64, cout64, ovf64}, 3'b000);
    step(2);

    // Directed vectors
    issue(8'h7F, 8'h01, ALUOP_ADD, 1); wait_done();
    chk("add7f01", {result, carry_out, overflow, zero}, {8'h80, 3'b010});
    step(1);
    issue(8'h05, 8'h05, ALUOP_SUB, 1); wait_done();
    chk("sub0505", {result, zero, carry_out, overflow}, {8'h00, 3'b110});
    step(1);
    issue(8'hF0, 8'h3C, ALUOP_AND, 1); wait_done();
    chk("and", result, 8'h30);
    step(1);
    issue(8'hF0, 8'h3C, ALUOP_OR, 1); wait_done();
    chk("or", result, 8'hFC);
    step(1);
    issue(8'hF0, 8'h3C, ALUOP_NOR, 1); wait_done();
    chk("nor", {result, carry_out, overflow}, {8'h03, 2'b00});
    step(1);

    // Back-to-back: chain the OR during the ADD's done cycle
    issue(8'hFF, 8'h01, ALUOP_ADD, 1); wait_done();
    chk("b2b_first", {result, carry_out}, {8'h00, 1'b1});
    t0 = cyc;
    issue(8'h0A, 8'h50, ALUOP_OR, 1);
    chk("b2b_done_drops", done, 1'b0);
    wait_done();
    chk("b2b_gap", cyc - t0, W + 1);
    chk("b2b_second", result, 8'h5A);
    step(1);

    // start during RUN is ignored
    issue(8'h33, 8'h44, ALUOP_ADD, 1);
    step(2);
    a_i = 8'hAA; b_i = 8'h55; op_i = ALUOP_AND; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("ignored_start", result, 8'h77);
    step(3);

    // Reset mid-RUN: in-flight op discarded
    issue(8'h12, 8'h34, ALUOP_ADD, 0);
    step(4);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", {busy, done, result, zero, carry_out, overflow}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(15);
    issue(8'h21, 8'h43, ALUOP_SUB, 1); wait_done();
    step(1);

    // Randomized ops, some chained in the done cycle
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), 1);
      wait_done();
      if ($urandom_range(0, 1) == 1) step($urandom_range(1, 3));
    end

    step(W + 4);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
